rr_burst_sched: RTL
===================

RR_BURST_SCHED -- requirements
Module: rr_burst_sched

Interface
REQ-001 SHALL have port: clk  input  1  clock; all state and registered outputs update on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: req  input  3  per-requester burst request, level, bit i = requester i.
REQ-004 SHALL have port: beat_last  input  1  owner's final beat, sampled only in RUN.
REQ-005 SHALL have port: abort  input  1  terminate current burst, sampled in GRANT and RUN.
REQ-006 SHALL have port: gnt  output  3  registered one-hot grant to the current owner.
REQ-007 SHALL have port: owner  output  2  registered index of the current owner (0..2).
REQ-008 SHALL have port: start  output  1  combinational one-cycle start strobe to the shared datapath.
REQ-009 SHALL have port: done  output  1  registered one-cycle burst-complete pulse.
REQ-010 SHALL have port: timeout  output  1  registered one-cycle pulse for a forced burst end.
REQ-011 SHALL have parameter: MAX_BEATS, default 16, meaning maximum RUN cycles per burst (2..16).

Function
REQ-012 SHALL implement states IDLE, GRANT, RUN, LAST, with a 2-bit state register updated from nextstate.
REQ-013 IDLE: if req != 0, SHALL go to GRANT and select the winner round-robin, searching ptr+1, ptr+2, ptr (mod 3); otherwise SHALL stay in IDLE.
REQ-014 Winner selection SHALL load owner and gnt on the same edge as entry to GRANT.
REQ-015 GRANT (1 cycle): start SHALL be 1 and the FSM SHALL go to RUN. If abort=1, start SHALL be 0 and the FSM SHALL go to LAST.
REQ-016 RUN: the 4-bit beat counter cnt SHALL be 0 on entry and SHALL increment each RUN cycle that stays in RUN.
REQ-017 RUN exit priority SHALL be: abort, then beat_last, then cnt == MAX_BEATS-1. Any of these SHALL move the FSM to LAST.
REQ-018 timeout SHALL pulse on the edge entering LAST only when the exit cause is the counter. beat_last and the limit in the same cycle SHALL NOT produce a timeout.
REQ-019 LAST (1 cycle): the FSM SHALL go to IDLE unconditionally, and ptr SHALL be loaded with owner.
REQ-020 done SHALL pulse high for the one cycle after LAST, i.e. registered on the LAST->IDLE transit.
REQ-021 gnt SHALL equal the onehot of owner in GRANT, RUN and LAST, and SHALL be 0 in IDLE (registered from nextstate).
REQ-022 owner SHALL hold its value through IDLE until the next arbitration.
REQ-023 Deassertion of the owner's req after grant SHALL NOT end the burst; only abort, beat_last or the limit end it.
REQ-024 There SHALL be a minimum of one IDLE cycle between consecutive bursts, so back-to-back bursts have a period of burst length + 3 cycles.
REQ-025 beat_last and abort SHALL be ignored in IDLE and LAST.
REQ-026 Unused state encoding SHALL return to IDLE on the next edge with all registered outputs 0.

Reset
REQ-027 On rst_n=0, the FSM SHALL be in IDLE, with gnt=0, owner=0, ptr=2 (so requester 0 has first priority), cnt=0, done=0 and timeout=0.
REQ-028 start SHALL be 0 during reset.
REQ-029 Reset asserted mid-burst SHALL drop gnt asynchronously with no done or timeout pulse.
REQ-030 After reset release, arbitration SHALL begin on the first edge with req != 0.

Verification
REQ-031 Single burst: req=3'b001 held, beat_last high on the 3rd RUN cycle -> gnt=001 for 5 cycles (GRANT+3 RUN+LAST), start in cycle 1, done 1 cycle after LAST, timeout=0.
REQ-032 Fairness: req=3'b111 held, beat_last=1 always -> owner sequence 0,1,2,0; each burst spans GRANT/RUN/LAST/IDLE = 4 cycles.
REQ-033 Timeout: req=3'b010, beat_last=0, MAX_BEATS=16 -> 16 RUN cycles, then LAST with timeout=1 pulse, then done=1.
REQ-034 Tie: beat_last=1 in the same cycle cnt=15 -> LAST, timeout=0, done=1.
REQ-035 Abort in GRANT: req=3'b100, abort=1 during GRANT -> start stays 0, LAST next, done=1, ptr=2, so the next req=3'b101 grants owner 0.
REQ-036 Reset mid-RUN: rst_n low at RUN cycle 2 -> gnt=000 immediately, done=0; after release with req=3'b110, owner=1 (ptr=2 restored).

Source files
------------

// File: rtl/rr_burst_sched_if.sv
// Handshake bundle between three burst requesters and the round-robin scheduler.
// Latency: none, wires only.
// Backpressure: none; the scheduler's grant is the only flow control.
interface rr_burst_sched_if;
  logic [2:0] req;
  logic       beat_last;
  logic       abort;
  logic [2:0] gnt;
  logic [1:0] owner;
  logic       start;
  logic       done;
  logic       timeout;

  // Requester side drives requests and burst control, observes the grant.
  modport master (
    output req, beat_last, abort,
    input  gnt, owner, start, done, timeout
  );

  // Scheduler side.
  modport slave (
    input  req, beat_last, abort,
    output gnt, owner, start, done, timeout
  );
endinterface

// File: rtl/rr_burst_sched.sv
// Three-way round-robin burst scheduler with beat limit, abort and forced-end timeout.
// Latency: grant registered one edge after req seen in IDLE; start is combinational in GRANT.
// Backpressure: none; a granted owner keeps the datapath until beat_last, abort or the limit.
module rr_burst_sched #(
  parameter int MAX_BEATS = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_burst_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RUN   = 2'd2,
    LAST  = 2'd3
  } state_t;

  // Counter value of the final allowed RUN cycle.
  localparam logic [3:0] BEAT_LIMIT = 4'(MAX_BEATS - 1);

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q,   ptr_d;
  logic [2:0] gnt_q,   gnt_d;
  logic [3:0] cnt_q,   cnt_d;
  logic       done_q,  done_d;
  logic       timeout_q, timeout_d;
  logic       start;

  logic [3:0] req_pad;
  logic [1:0] cand0, cand1, cand2;
  logic [1:0] win;

  // Round-robin winner: search ptr+1, ptr+2, then ptr itself (mod 3).
  always_comb begin
    req_pad = {1'b0, bus.req};
    cand0   = 2'd0;
    cand1   = 2'd1;
    cand2   = 2'd2;
    case (ptr_q)
      2'd0: begin
        cand0 = 2'd1;
        cand1 = 2'd2;
        cand2 = 2'd0;
      end
      2'd1: begin
        cand0 = 2'd2;
        cand1 = 2'd0;
        cand2 = 2'd1;
      end
      default: begin
        cand0 = 2'd0;
        cand1 = 2'd1;
        cand2 = 2'd2;
      end
    endcase
    if (req_pad[cand0]) begin
      win = cand0;
    end else if (req_pad[cand1]) begin
      win = cand1;
    end else begin
      win = cand2;
    end
  end

  // Next-state, arbitration load, beat counting and pulse generation.
  always_comb begin
    state_d   = IDLE;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = 4'd0;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    start     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = GRANT;
          owner_d = win;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (bus.abort) begin
          state_d = LAST;
        end else begin
          state_d = RUN;
          start   = 1'b1;
        end
      end
      RUN: begin
        // Abort beats beat_last beats the limit; only a pure limit exit is a timeout.
        if (bus.abort) begin
          state_d = LAST;
        end else if (bus.beat_last) begin
          state_d = LAST;
        end else if (cnt_q == BEAT_LIMIT) begin
          state_d   = LAST;
          timeout_d = 1'b1;
        end else begin
          state_d = RUN;
          cnt_d   = cnt_q + 4'd1;
        end
      end
      LAST: begin
        state_d = IDLE;
        ptr_d   = owner_q;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        owner_d = 2'd0;
      end
    endcase
    // Grant follows the state being entered, so it is clean in IDLE.
    gnt_d = (state_d == IDLE) ? 3'b000 : (3'b001 << owner_d);
  end

  // State and registered outputs; ptr resets to 2 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 2'd0;
      ptr_q     <= 2'd2;
      gnt_q     <= 3'b000;
      cnt_q     <= 4'd0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.owner   = owner_q;
  assign bus.start   = start;
  assign bus.done    = done_q;
  assign bus.timeout = timeout_q;

endmodule
